// File: rtl/multiword_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sequencer_if
// Purpose  : Operand/result handshake and 16-bit adder-slice bus for
//            multiword_add_sequencer. The sub signal exists only when
//            MULTIWORD_ADD_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface multiword_add_sequencer_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   a;
    logic [16*WORDS-1:0]   b;
    logic                  cin;
`ifdef MULTIWORD_ADD_SUB_EN
    logic                  sub;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   sum;
    logic                  cout;
    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic                  add_cin;
    logic [15:0]           add_sum;
    logic                  add_cout;

    // Environment side: operand producer, result consumer and the adder stage.
    modport master (
        output in_valid, a, b, cin,
`ifdef MULTIWORD_ADD_SUB_EN
        output sub,
`endif
        output out_ready, add_sum, add_cout,
        input  in_ready, out_valid, sum, cout, add_a, add_b, add_cin
    );

    modport slave (
        input  in_valid, a, b, cin,
`ifdef MULTIWORD_ADD_SUB_EN
        input  sub,
`endif
        input  out_ready, add_sum, add_cout,
        output in_ready, out_valid, sum, cout, add_a, add_b, add_cin
    );
endinterface
`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sequencer
// Purpose  : Issues a 16*WORDS-bit addition as WORDS 16-bit slices (LSB first)
//            to an external adder, rippling the carry. Optional subtract mode
//            enabled by macro MULTIWORD_ADD_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  wire                          clk,
    input  wire                          rst,
    multiword_add_sequencer_if.slave     bus
);
    localparam int                 c_IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int                 c_W        = 16 * WORDS;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_W-1:0]       r_a;
    logic [c_W-1:0]       r_b;
    logic [c_W-1:0]       r_sum;
    logic                 r_cout;
    logic                 r_carry;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [15:0]          r_add_a;
    logic [15:0]          r_add_b;

    logic [c_W-1:0]       w_b_in;
    logic                 w_cin_in;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic                 w_last;

`ifdef MULTIWORD_ADD_SUB_EN
    // Subtraction as a + ~b + 1: the forced slice-0 carry completes the negation.
    assign w_b_in   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_in = bus.sub | bus.cin;
`else
    assign w_b_in   = bus.b;
    assign w_cin_in = bus.cin;
`endif

    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (r_idx == c_LAST_IDX);

    // Adder slice operands are registered one edge ahead, so add_a/add_b
    // always show slice r_idx while in RUN and zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= w_b_in;
                        r_sum      <= '0;
                        r_idx      <= '0;
                        r_carry    <= w_cin_in;
                        r_add_a    <= bus.a[15:0];
                        r_add_b    <= w_b_in[15:0];
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[{r_idx, 4'b0000} +: 16] <= bus.add_sum;
                    if (w_last) begin
                        r_cout      <= bus.add_cout;
                        r_carry     <= 1'b0;
                        r_idx       <= '0;
                        r_add_a     <= '0;
                        r_add_b     <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_carry <= bus.add_cout;
                        r_idx   <= w_idx_nxt;
                        r_add_a <= r_a[{w_idx_nxt, 4'b0000} +: 16];
                        r_add_b <= r_b[{w_idx_nxt, 4'b0000} +: 16];
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_cin   = r_carry;
endmodule
`default_nettype wire
